// File: rtl/array_8_ofm_drain_if.sv
// Bus between the systolic array column outputs, the drain block and the row consumer.
// The slave modport is the drain's view of the bus; the master modport is the array/consumer view.
interface array_8_ofm_drain_if #(
  parameter int WIDTH  = 8,
  parameter int OWIDTH = 24,
  parameter int QWIDTH = 16
);
  logic [WIDTH-1:0]         col_vld;
  logic signed [OWIDTH-1:0] ofm [WIDTH];
  logic                     clr_err;
  logic                     out_vld;
  logic                     out_rdy;
  logic signed [QWIDTH-1:0] out_data [WIDTH];
  logic                     busy;
  logic                     ovf_err;
  logic                     dup_err;

  modport master (
    output col_vld, ofm, clr_err, out_rdy,
    input  out_vld, out_data, busy, ovf_err, dup_err
  );

  modport slave (
    input  col_vld, ofm, clr_err, out_rdy,
    output out_vld, out_data, busy, ovf_err, dup_err
  );
endinterface

// File: rtl/array_8_ofm_drain.sv
// Collects skewed per-column array results, quantizes them, assembles complete rows
// and buffers those rows in a small FIFO in front of a valid/ready consumer.
module array_8_ofm_drain #(
  parameter int WIDTH  = 8,
  parameter int OWIDTH = 24,
  parameter int QWIDTH = 16,
  parameter int SHIFT  = 8,
  parameter int DEPTH  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  array_8_ofm_drain_if.slave   bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic signed [OWIDTH-1:0] QMAX = OWIDTH'((1 << (QWIDTH - 1)) - 1);
  localparam logic signed [OWIDTH-1:0] QMIN = ~QMAX;

  typedef logic [WIDTH-1:0][QWIDTH-1:0] row_t;

  logic [QWIDTH-1:0] qv [WIDTH];
  row_t              asm_q, asm_d, new_row;
  row_t              head_q, head_d;
  row_t              mem_q [DEPTH];
  logic [WIDTH-1:0]  filled_q, filled_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d, dup_q, dup_d;
  logic              complete, full, pop, push_ok, ovf_set, dup_set;

  // Quantize at capture: arithmetic shift, then clamp into the signed QWIDTH range.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_quant
    logic signed [OWIDTH-1:0] shifted;
    assign shifted = bus.ofm[gi] >>> SHIFT;
    assign qv[gi]  = (shifted > QMAX) ? QMAX[QWIDTH-1:0] :
                     (shifted < QMIN) ? QMIN[QWIDTH-1:0] : shifted[QWIDTH-1:0];
  end

  always_comb begin
    new_row  = asm_q;
    for (int w = 0; w < WIDTH; w++) begin
      if (bus.col_vld[w]) new_row[w] = qv[w];
    end
    asm_d    = new_row;
    complete = &(filled_q | bus.col_vld);
    filled_d = complete ? '0 : (filled_q | bus.col_vld);
    dup_set  = !complete && (|(bus.col_vld & filled_q));

    pop      = (count_q != '0) && bus.out_rdy;
    full     = (count_q == CW'(DEPTH));
    push_ok  = complete && (!full || pop);
    ovf_set  = complete && full && !pop;
    count_d  = count_q + CW'(push_ok) - CW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);

    // The new head may be the row being written this very edge (empty FIFO, or one entry popping).
    head_d   = (push_ok && (wr_ptr_q == rd_ptr_d)) ? new_row : mem_q[rd_ptr_d];

    ovf_d    = ovf_set | (ovf_q & ~bus.clr_err);
    dup_d    = dup_set | (dup_q & ~bus.clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      asm_q    <= '0;
      head_q   <= '0;
      filled_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      dup_q    <= 1'b0;
    end else begin
      asm_q    <= asm_d;
      head_q   <= head_d;
      filled_q <= filled_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      dup_q    <= dup_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= new_row;
  end

  assign bus.out_vld = (count_q != '0);
  assign bus.busy    = (filled_q != '0) || (count_q != '0);
  assign bus.ovf_err = ovf_q;
  assign bus.dup_err = dup_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
    assign bus.out_data[gi] = head_q[gi];
  end
endmodule

// File: doc/array_8_ofm_drain.md
ARRAY_8_OFM_DRAIN -- requirements
Module: array_8_ofm_drain

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- WIDTH, 8, array columns.
- OWIDTH, 24, raw ofm width.
- QWIDTH, 16, quantized output width.
- SHIFT, 8, arithmetic right shift applied before saturation.
- DEPTH, 2, row FIFO entries (power of 2, at least 2).

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- col_vld  in  WIDTH  per-column capture strobe; column w result is valid on ofm[w] this cycle.
- ofm  in  signed OWIDTH x WIDTH (unpacked array)  column results from the array.
- clr_err  in  1  clears sticky error flags.
- out_vld  out  1  head FIFO row available.
- out_rdy  in  1  consumer accepts the row when out_vld is also high.
- out_data  out  signed QWIDTH x WIDTH (unpacked array)  quantized row, element w from column w.
- busy  out  1  any column captured for the row being assembled, or FIFO not empty.
- ovf_err  out  1  sticky; a completed row was dropped.
- dup_err  out  1  sticky; a column was strobed twice before its row completed.

Function
REQ-003 The block SHALL hold an assembly register: WIDTH values, each QWIDTH bits, plus a WIDTH-bit filled mask.
REQ-004 Quantization per column SHALL be applied at capture:
- Compute q = ofm[w] >>> SHIFT (arithmetic shift).
- Saturate q to [-2^(QWIDTH-1), 2^(QWIDTH-1)-1].
- Store the result in assembly slot w.
REQ-005 Columns SHALL be captured independently and in any order or skew; col_vld[w] high captures slot w and sets filled[w].
REQ-006 A row SHALL be complete in the cycle where (filled | col_vld) equals all-ones. Strobes arriving in that cycle belong to the completing row.
REQ-007 On completion the block SHALL, in the same edge:
- Push the merged row into the FIFO, with slots from that cycle's strobes taking the incoming quantized values.
- Clear filled to zero.
REQ-008 col_vld[w] while filled[w] is already set, in a cycle that does not complete the row, SHALL overwrite slot w and set dup_err.
REQ-009 FIFO occupancy SHALL be tracked by a counter ranging 0..DEPTH, with wrap-around read and write pointers.
REQ-010 out_vld SHALL equal (count != 0). out_data SHALL present the head entry, registered, with no combinational path from ofm.
REQ-011 A pop SHALL occur when out_vld and out_rdy are both high; the head advances on that edge.
REQ-012 Latency: a row completing at edge N SHALL make out_vld high after edge N when the FIFO was empty.
REQ-013 Push with count == DEPTH and no pop in the same cycle SHALL drop the row, set ovf_err, and leave the FIFO unchanged.
REQ-014 Push with count == DEPTH and a pop in the same cycle SHALL be accepted; count stays DEPTH.
REQ-015 Push and pop in the same cycle at any other count SHALL leave count unchanged. Push with count == 0 and out_rdy high SHALL NOT bypass; the row appears after the next edge.
REQ-016 out_data and out_vld SHALL stay stable while out_vld is high and out_rdy is low.
REQ-017 clr_err SHALL clear ovf_err and dup_err. When a set event occurs in the same cycle as clr_err, set SHALL win.
REQ-018 busy SHALL equal (filled != 0) OR (count != 0).

Reset
REQ-019 While rst_n is low at a clock edge, the block SHALL reset:
- filled, count, both pointers, ovf_err and dup_err to 0.
- out_vld and busy to 0.
- out_data to all zeros.
REQ-020 Reset mid-row or mid-FIFO SHALL discard partial rows and buffered rows. No output SHALL appear after rst_n rises until a new complete row is assembled.
REQ-021 col_vld and out_rdy SHALL be ignored while rst_n is low.

Verification
REQ-022 Skewed capture, SHIFT=8:
- Stimulus: col_vld[w] pulses at cycle w with ofm[w] = (w+1)*256, out_rdy=1.
- Required: out_vld rises after edge 7 with out_data = {1,2,...,8}, a single beat, busy returns to 0.
REQ-023 Saturation:
- Stimulus: ofm = 24'h7FFFFF on column 0 and 24'h800000 on column 1; other columns = 0.
- Required: out_data[0] = 32767, out_data[1] = -32768, rest 0.
REQ-024 Backpressure, DEPTH=2:
- Stimulus: three complete rows with out_rdy=0.
- Required: rows 1 and 2 are held; row 3 is dropped; ovf_err=1.
- Then: out_rdy=1 yields rows 1 and 2 in order; clr_err clears ovf_err.
REQ-025 Full-with-pop:
- Stimulus: FIFO full, row completes in the same cycle a pop occurs.
- Required: no drop, ovf_err stays 0, the three rows emerge in order.
REQ-026 Duplicate strobe:
- Stimulus: column 3 strobed with 512, then 768, before the row completes.
- Required: dup_err=1, out_data[3] = 3.
REQ-027 Reset mid-row:
- Stimulus: four columns captured, then rst_n low for one cycle, then the four remaining columns strobed.
- Required: no out_vld; filled equals the upper four bits only; busy=1.
